// File: rtl/uart_rx_control_module.sv
// uart_rx_control_module: 16x-oversampling UART receiver, 8 data bits LSB first.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after D7).
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_pin_in    serial line, idle high
//   rx_data      last received byte, held until the next rx_done_sig
//   rx_done_sig  one-clk pulse when a frame completes
//   frame_err    stop bit sampled low, updated with rx_done_sig
//   parity_err   even-parity mismatch, updated with rx_done_sig (0 without parity)
//   busy         high from a validated start bit until the FSM returns to IDLE
module uart_rx_control_module #(
  parameter int unsigned CLKS_PER_TICK = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin_in,
  output logic [7:0] rx_data,
  output logic       rx_done_sig,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int unsigned SAMP_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e state_q, state_d;

  logic              sync1_q, sync2_q, prev_q;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [1:0]        vote_q, vote_d;
  logic              start_ok_q, start_ok_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic              par_bit_q, par_bit_d;
  logic              perr_q, perr_d;
`endif

  logic rx_s, fall_c, tick_c, t7_c, t8_c, mid_c, bit_end_c, maj_c, enter_start_c;

  assign rx_s      = sync2_q;
  assign fall_c    = prev_q & ~rx_s;
  assign tick_c    = (tick_cnt_q == TICK_W'(CLKS_PER_TICK - 1));
  assign t7_c      = tick_c && (samp_cnt_q == SAMP_W'(7));
  assign t8_c      = tick_c && (samp_cnt_q == SAMP_W'(8));
  assign mid_c     = tick_c && (samp_cnt_q == SAMP_W'(9));
  assign bit_end_c = tick_c && (samp_cnt_q == SAMP_W'(15));
  // Majority of the tick 7/8 samples and the live tick-9 sample.
  assign maj_c     = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
  assign enter_start_c = (state_q == S_IDLE) && (state_d == S_START);

  // Input synchronizer and edge history; idle-high reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (fall_c) state_d = S_START;
      // Validate at mid start bit, then run the start bit out so data windows align.
      S_START: begin
        if (t7_c && rx_s)   state_d = S_IDLE;
        else if (bit_end_c) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end_c && (bit_idx_q == IDX_W'(7))) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:    if (bit_end_c) state_d = S_STOP;
`endif
      // Finish at the stop-bit decision so the next start edge is caught promptly.
      S_STOP:      if (mid_c) state_d = maj_c ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    vote_d     = vote_q;
    start_ok_d = start_ok_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
`endif

    if (enter_start_c) begin
      tick_cnt_d = '0;
      samp_cnt_d = '0;
      start_ok_d = 1'b0;
    end else if ((state_q != S_IDLE) && tick_c) begin
      samp_cnt_d = samp_cnt_q + SAMP_W'(1);
    end

    if (t7_c) vote_d[1] = rx_s;
    if (t8_c) vote_d[0] = rx_s;

    case (state_q)
      S_START: if (t7_c && !rx_s) start_ok_d = 1'b1;
      S_DATA: begin
        if (mid_c)     shreg_d   = {maj_c, shreg_q[DATA_W-1:1]};
        if (bit_end_c) bit_idx_d = bit_idx_q + IDX_W'(1);
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (mid_c) par_bit_d = maj_c;
`endif
      S_STOP: begin
        if (mid_c) begin
          rx_data_d = shreg_q;
          ferr_d    = ~maj_c;
          done_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d    = (^shreg_q) ^ par_bit_q;
`endif
        end
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && !((state_d == S_START) && !start_ok_d);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      vote_q     <= '0;
      start_ok_q <= 1'b0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      vote_q     <= vote_d;
      start_ok_q <= start_ok_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_done_sig = done_q;
  assign frame_err   = ferr_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_control_module.sv
// Directed bench for uart_rx_control_module with a short tick period.
module tb_uart_rx_control_module;

  localparam int unsigned K   = 4;
  localparam int unsigned BIT = 16 * K;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_pin_in;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_control_module #(.CLKS_PER_TICK(K)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_pin_in   (rx_pin_in),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts done pulses, captures outputs, tracks pulse width.
  int         done_cnt = 0;
  int         run      = 0;
  int         max_run  = 0;
  int         done_cyc = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] cap_data [0:63];
  logic       cap_ferr [0:63];
  logic       cap_perr [0:63];

  always @(negedge clk) begin
    if (rx_done_sig === 1'b1) begin
      run = run + 1;
      if (run == 1) begin
        if (done_cnt < 64) begin
          cap_data[done_cnt] = rx_data;
          cap_ferr[done_cnt] = frame_err;
          cap_perr[done_cnt] = parity_err;
        end
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int stop_cyc = 0;

  task automatic send_bit(input logic b);
    rx_pin_in = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_data(d);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    stop_cyc = cyc;
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_data(d);
    send_bit(par);
    stop_cyc = cyc;
    send_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    rx_pin_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int d0;
  int lat;

  initial begin
    rst_n     = 1'b0;
    rx_pin_in = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("reset rx_data", 32'(rx_data), 32'h00);
    check_eq("reset done", 32'(rx_done_sig), 32'h0);
    check_eq("reset frame_err", 32'(frame_err), 32'h0);
    check_eq("reset parity_err", 32'(parity_err), 32'h0);
    check_eq("reset busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(2 * BIT);

    // Basic frame 0x55.
    d0 = done_cnt;
    send_frame(8'h55, 1'b1);
    idle(4);
    lat = done_cyc - stop_cyc;
    check_eq("0x55 pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("0x55 data", 32'(rx_data), 32'h55);
    check_eq("0x55 frame_err", 32'(frame_err), 32'h0);
    check_eq("0x55 parity_err", 32'(parity_err), 32'h0);
    check_eq("0x55 busy after", 32'(busy), 32'h0);
    check_eq("0x55 latency window", 32'((lat >= int'(9 * K)) && (lat <= int'(11 * K + 6))), 32'd1);

    // Start-bit glitch of 4 ticks is rejected.
    idle(BIT);
    d0 = done_cnt;
    busy_seen = 1'b0;
    rx_pin_in = 1'b0;
    repeat (4 * K) @(negedge clk);
    idle(2 * BIT);
    check_eq("glitch pulses", 32'(done_cnt - d0), 32'd0);
    check_eq("glitch busy", 32'(busy_seen), 32'h0);
    send_frame(8'hC3, 1'b1);
    idle(4);
    check_eq("after glitch pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("after glitch data", 32'(rx_data), 32'hC3);

    // Framing error with a long break.
    idle(BIT);
    d0 = done_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (39 * BIT) @(negedge clk);
    check_eq("break pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("break data", 32'(rx_data), 32'hA3);
    check_eq("break frame_err", 32'(frame_err), 32'h1);
    check_eq("break busy held", 32'(busy), 32'h1);
    idle(2 * BIT);
    check_eq("break release pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("break release busy", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b1);
    idle(4);
    check_eq("post-break pulses", 32'(done_cnt - d0), 32'd2);
    check_eq("post-break data", 32'(rx_data), 32'h5A);
    check_eq("post-break frame_err", 32'(frame_err), 32'h0);

    // Back-to-back frames with no idle gap.
    idle(BIT);
    d0 = done_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    check_eq("b2b pulses", 32'(done_cnt - d0), 32'd2);
    check_eq("b2b first data", 32'(cap_data[d0]), 32'h00);
    check_eq("b2b first frame_err", 32'(cap_ferr[d0]), 32'h0);
    check_eq("b2b second data", 32'(cap_data[d0 + 1]), 32'hFF);
    check_eq("b2b second frame_err", 32'(cap_ferr[d0 + 1]), 32'h0);

    // Reset during D4 of 0x3C discards the partial byte.
    idle(BIT);
    d0 = done_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_pin_in = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid reset busy", 32'(busy), 32'h0);
    check_eq("mid reset data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    idle(12 * BIT);
    check_eq("mid reset pulses", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h81, 1'b1);
    idle(4);
    check_eq("post reset pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("post reset data", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so a correct parity bit is 1.
    idle(BIT);
    d0 = done_cnt;
    send_frame_par(8'h07, 1'b0);
    idle(4);
    check_eq("par0 pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("par0 parity_err", 32'(parity_err), 32'h1);
    send_frame_par(8'h07, 1'b1);
    idle(4);
    check_eq("par1 pulses", 32'(done_cnt - d0), 32'd2);
    check_eq("par1 parity_err", 32'(parity_err), 32'h0);
    check_eq("par1 data", 32'(rx_data), 32'h07);
`endif

    check_eq("done pulse width", 32'(max_run), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
